// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Bundles the command, response and data-memory signals of the
//            memory access unit. The "slave" modport is the unit's view.
//            The "master" modport is the pipeline/memory environment's view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_wdata;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // data memory port
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_len, cmd_wdata,
        input  rsp_ready, mem_read_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_len, cmd_wdata,
        output rsp_ready, mem_read_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Initiator-side controller for the data memory port. It executes
//            load, store and block-copy commands and returns one response
//            per command.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  wire               clk,
    input  wire               rst_n,
    mem_access_unit_if.slave  bus,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] c_op_load  = 2'b00;
    localparam logic [1:0] c_op_store = 2'b01;
    localparam logic [1:0] c_op_copy  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STORE   = 3'd2,
        S_COPY_RD = 3'd3,
        S_COPY_WR = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_err;
    logic              w_last;
    logic [ADDR_W-1:0] w_idx_inc;
    logic [ADDR_W:0]   w_src_end;
    logic [ADDR_W:0]   w_dst_end;

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (w_idx_inc >= r_len);

    // Range/op check on the incoming command, one bit wider so sums cannot wrap
    always_comb begin
        w_src_end = {1'b0, bus.cmd_src} + {1'b0, bus.cmd_len};
        w_dst_end = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
        w_err     = 1'b1;
        case (bus.cmd_op)
            c_op_load, c_op_store: w_err = ({1'b0, bus.cmd_addr} >= c_depth);
            c_op_copy:             w_err = (bus.cmd_len != '0) &&
                                           ((w_src_end > c_depth) || (w_dst_end > c_depth));
            default:               w_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-decoded outputs (memory lines idle at zero)
    always_comb begin
        w_next               = r_state;
        bus.cmd_ready        = 1'b0;
        bus.rsp_valid        = 1'b0;
        busy                 = 1'b1;
        bus.mem_address      = '0;
        bus.mem_write_data   = '0;
        bus.mem_write_enable = 1'b0;
        bus.mem_read_enable  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else begin
                        case (bus.cmd_op)
                            c_op_load:  w_next = S_LOAD;
                            c_op_store: w_next = S_STORE;
                            c_op_copy:  w_next = (bus.cmd_len == '0) ? S_RESP : S_COPY_RD;
                            default:    w_next = S_RESP;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                bus.mem_address     = r_addr;
                bus.mem_read_enable = 1'b1;
                w_next              = S_RESP;
            end
            S_STORE: begin
                bus.mem_address      = r_addr;
                bus.mem_write_data   = r_wdata;
                bus.mem_write_enable = 1'b1;
                w_next               = S_RESP;
            end
            S_COPY_RD: begin
                bus.mem_address     = r_src + r_idx;
                bus.mem_read_enable = 1'b1;
                w_next              = S_COPY_WR;
            end
            S_COPY_WR: begin
                bus.mem_address      = r_addr + r_idx;
                bus.mem_write_data   = r_buf;
                bus.mem_write_enable = 1'b1;
                w_next               = w_last ? S_RESP : S_COPY_RD;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, copy index/buffer and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_src      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.cmd_addr;
                        r_src      <= bus.cmd_src;
                        r_len      <= bus.cmd_len;
                        r_wdata    <= bus.cmd_wdata;
                        r_idx      <= '0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= w_err;
                    end
                end
                S_LOAD:    r_rsp_data <= bus.mem_read_data;
                S_COPY_RD: r_buf      <= bus.mem_read_data;
                S_COPY_WR: begin
                    r_idx <= w_idx_inc;
                    if (w_last) begin
                        r_rsp_data <= DATA_W'(r_len);
                    end
                end
                S_RESP: begin
                    // clear after the handshake so an idle unit shows zeros
                    if (bus.rsp_ready) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_data = r_rsp_data;
    assign bus.rsp_err  = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. It uses directed and
//            random commands against an array-based reference model of the
//            memory and of the expected response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // ---------------- physical data memory attached to the DUT ------------
    logic [DATA_W-1:0] phys [DEPTH] = '{default: '0};
    int                total_rd = 0;
    logic [ADDR_W-1:0] act_wa [$];
    logic [DATA_W-1:0] act_wd [$];

    assign bus.mem_read_data = (bus.mem_address < ADDR_W'(DEPTH)) ? phys[bus.mem_address[2:0]] : '0;

    // Memory write and access logging
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.mem_write_enable) begin
                if (bus.mem_address < ADDR_W'(DEPTH)) phys[bus.mem_address[2:0]] <= bus.mem_write_data;
                act_wa.push_back(bus.mem_address);
                act_wd.push_back(bus.mem_write_data);
            end
            if (bus.mem_read_enable) total_rd++;
        end
    end

    // Checking task
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus hygiene: enables exclusive, idle memory lines at zero
    always @(negedge clk) begin
        check_value("en_exclusive", 32'(bus.mem_read_enable & bus.mem_write_enable), 0);
        if (!bus.mem_read_enable && !bus.mem_write_enable) begin
            check_value("idle_mem_addr", 32'(bus.mem_address), 0);
            check_value("idle_mem_wdata", 32'(bus.mem_write_data), 0);
        end
    end

    // ---------------- reference model -------------------------------------
    logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
    int                exp_rd;
    logic [ADDR_W-1:0] exp_wa [$];
    logic [DATA_W-1:0] exp_wd [$];

    task automatic model(input int op, input int addr, input int src, input int len,
                         input logic [DATA_W-1:0] wd,
                         output logic [DATA_W-1:0] ed, output logic ee, output int elat);
        exp_rd = 0;
        exp_wa.delete();
        exp_wd.delete();
        ed = '0; ee = 1'b0; elat = 1;
        if (op == 3) ee = 1'b1;
        else if (op < 2 && addr >= DEPTH) ee = 1'b1;
        else if (op == 2 && len > 0 && (src + len > DEPTH || addr + len > DEPTH)) ee = 1'b1;
        else if (op == 0) begin
            ed = ref_mem[addr]; exp_rd = 1; elat = 2;
        end else if (op == 1) begin
            ref_mem[addr] = wd;
            exp_wa.push_back(ADDR_W'(addr)); exp_wd.push_back(wd); elat = 2;
        end else begin
            for (int i = 0; i < len; i++) begin
                ref_mem[addr+i] = ref_mem[src+i];
                exp_wa.push_back(ADDR_W'(addr + i)); exp_wd.push_back(ref_mem[src+i]);
            end
            exp_rd = len; elat = 2 * len + 1; ed = DATA_W'(len);
        end
    endtask

    // ---------------- driver tasks ----------------------------------------
    task automatic issue(input int op, input int addr, input int src, input int len,
                         input logic [DATA_W-1:0] wd);
        int n = 0;
        @(negedge clk);
        bus.cmd_op    = op[1:0];
        bus.cmd_addr  = addr[ADDR_W-1:0];
        bus.cmd_src   = src[ADDR_W-1:0];
        bus.cmd_len   = len[ADDR_W-1:0];
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_value("accept_bound", 32'(n < 100), 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int elat);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 200);
        check_value("rsp_latency", lat, elat);
    endtask

    task automatic finish_rsp(input int stall, input logic [DATA_W-1:0] ed, input logic ee);
        check_value("rsp_data", 32'(bus.rsp_data), 32'(ed));
        check_value("rsp_err", 32'(bus.rsp_err), 32'(ee));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_value("stall_valid", 32'(bus.rsp_valid), 1);
            check_value("stall_data", 32'(bus.rsp_data), 32'(ed));
            check_value("stall_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check_value("post_hs_cmd_ready", 32'(bus.cmd_ready), 1);
        check_value("post_hs_rsp_valid", 32'(bus.rsp_valid), 0);
    endtask

    task automatic compare_logs(input int rd_base, input int wbase);
        check_value("rd_count", 32'(total_rd - rd_base), 32'(exp_rd));
        check_value("wr_count", 32'(act_wa.size() - wbase), 32'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size(); i++) begin
            if (wbase + i < act_wa.size()) begin
                check_value("wr_addr", 32'(act_wa[wbase+i]), 32'(exp_wa[i]));
                check_value("wr_data", 32'(act_wd[wbase+i]), 32'(exp_wd[i]));
            end
        end
    endtask

    task automatic compare_mem();
        for (int i = 0; i < DEPTH; i++) check_value($sformatf("mem[%0d]", i), 32'(phys[i]), 32'(ref_mem[i]));
    endtask

    task automatic run_cmd(input int op, input int addr, input int src, input int len,
                           input logic [DATA_W-1:0] wd, input int stall);
        logic [DATA_W-1:0] ed;
        logic ee;
        int elat, rd_base, wbase;
        model(op, addr, src, len, wd, ed, ee, elat);
        rd_base = total_rd;
        wbase   = act_wa.size();
        issue(op, addr, src, len, wd);
        wait_rsp(elat);
        finish_rsp(stall, ed, ee);
        compare_logs(rd_base, wbase);
        compare_mem();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check_value({tag, "_busy"}, 32'(busy), 0);
        check_value({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check_value({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        check_value({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        check_value({tag, "_mem_addr"}, 32'(bus.mem_address), 0);
        check_value({tag, "_mem_wdata"}, 32'(bus.mem_write_data), 0);
        check_value({tag, "_mem_we"}, 32'(bus.mem_write_enable), 0);
        check_value({tag, "_mem_re"}, 32'(bus.mem_read_enable), 0);
    endtask

    function automatic int pick_addr();
        int r = $urandom_range(0, 9);
        if (r == 9) return 32'hFFF0 + $urandom_range(0, 15);
        return r;
    endfunction

    // ---------------- main sequence ---------------------------------------
    initial begin
        logic [DATA_W-1:0] ed;
        logic ee;
        int elat, n, wbase, rd_base;
        int op, addr, src, len;

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_src = '0;
        bus.cmd_len = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // store then load back
        run_cmd(1, 3, 0, 0, 16'hBEEF, 0);
        run_cmd(0, 3, 0, 0, 16'h0000, 0);

        // range errors
        run_cmd(0, 8, 0, 0, 16'h0000, 0);
        run_cmd(2, 0, 6, 3, 16'h0000, 0);
        run_cmd(2, 16'hFFFF, 0, 2, 16'h0000, 1);

        // preload and copy 0..3 -> 4..7
        for (int i = 0; i < DEPTH; i++) run_cmd(1, i, 0, 0, DATA_W'(16'h10 + i), 0);
        run_cmd(2, 4, 0, 4, 16'h0000, 0);

        // zero-length copy and reserved op
        run_cmd(2, 1, 2, 0, 16'h0000, 0);
        run_cmd(3, 1, 0, 0, 16'h1234, 0);

        // overlapping copy with dst above src replicates data
        run_cmd(2, 1, 0, 4, 16'h0000, 2);

        // stalled load response with a pending store
        model(0, 3, 0, 0, '0, ed, ee, elat);
        issue(0, 3, 0, 0, '0);
        wait_rsp(elat);
        check_value("stall_load_data", 32'(bus.rsp_data), 32'(ed));
        bus.cmd_op = 2'b01; bus.cmd_addr = 16'd5; bus.cmd_wdata = 16'h5A5A; bus.cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_value("stall_valid", 32'(bus.rsp_valid), 1);
            check_value("stall_data", 32'(bus.rsp_data), 32'(ed));
            check_value("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check_value("stall_no_store", 32'(phys[5]), 32'(ref_mem[5]));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check_value("hs_edge_cmd_ready", 32'(bus.cmd_ready), 1);
        check_value("hs_edge_busy", 32'(busy), 0);
        model(1, 5, 0, 0, 16'h5A5A, ed, ee, elat);
        rd_base = total_rd;
        wbase   = act_wa.size();
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        check_value("pending_accepted_busy", 32'(busy), 1);
        wait_rsp(elat);
        finish_rsp(0, ed, ee);
        compare_logs(rd_base, wbase);
        compare_mem();

        // randomized commands
        for (int t = 0; t < 150; t++) begin
            op   = $urandom_range(0, 3);
            addr = pick_addr();
            src  = pick_addr();
            len  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : $urandom_range(0, 5);
            run_cmd(op, addr, src, len, DATA_W'($urandom), $urandom_range(0, 3));
        end

        // reset during the third write of a 4-word copy
        for (int i = 0; i < 4; i++) run_cmd(1, i, 0, 0, DATA_W'(16'hA0 + i), 0);
        wbase = act_wa.size();
        issue(2, 4, 0, 4, '0);
        n = 0;
        while (!(bus.mem_write_enable && (act_wa.size() - wbase) == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("reach_third_write", 32'(n < 50), 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midcopy_reset");
        for (int i = 0; i < 2; i++) ref_mem[4+i] = ref_mem[i];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("no_rsp_after_abort", 32'(bus.rsp_valid), 0);
        end
        compare_mem();
        run_cmd(0, 5, 0, 0, '0, 0);
        run_cmd(2, 2, 4, 2, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
